// File: rtl/pit_irq_sequencer.sv
// Config sequencer and interrupt arbiter for a bank of interval timer channels.
// Define PIT_RR_ARB_EN for round-robin grants; fixed lowest-index priority otherwise.
module pit_irq_sequencer #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [3:0]            cfg_addr,
    input  logic [7:0]            cfg_data,
    output logic [NUM_CH-1:0]     ch_write_enable,
    output logic [8*NUM_CH-1:0]   ch_counter_high,
    output logic [8*NUM_CH-1:0]   ch_counter_low,
    output logic [NUM_CH-1:0]     ch_repeating,
    output logic [NUM_CH-1:0]     ch_divider_on,
    input  logic [NUM_CH-1:0]     ch_interrupting,
    output logic                  irq,
    output logic [ID_W-1:0]       irq_id,
    input  logic                  irq_ack,
    output logic [NUM_CH-1:0]     overrun
);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE} state_t;

    state_t            state;
    logic [1:0]        cur_ch;
    logic [7:0]        sh_low  [NUM_CH];
    logic [7:0]        sh_high [NUM_CH];
    logic [NUM_CH-1:0] sh_rep;
    logic [NUM_CH-1:0] sh_div;
    logic [NUM_CH-1:0] irq_en;
    logic [NUM_CH-1:0] pending;

    logic [1:0]        cfg_ch;
    logic [1:0]        cfg_reg;
    logic              accept;
    logic              ctrl_wr;
    logic              unused_bits;

    logic [NUM_CH-1:0] pend_set;
    logic [NUM_CH-1:0] ack_clr;
    logic [NUM_CH-1:0] en_clr;
    logic [NUM_CH-1:0] ovr_set;
    logic [NUM_CH-1:0] ovr_clr;
    logic [ID_W-1:0]   grant_id;

    assign cfg_ch      = cfg_addr[3:2];
    assign cfg_reg     = cfg_addr[1:0];
    assign accept      = cfg_valid & cfg_ready;
    assign ctrl_wr     = accept && (cfg_reg == 2'd2);
    assign unused_bits = ^cfg_data[7:4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cfg_ready       <= 1'b1;
            cur_ch          <= '0;
            ch_write_enable <= '1;
            ch_counter_high <= '0;
            ch_counter_low  <= '0;
            ch_repeating    <= '0;
            ch_divider_on   <= '0;
            sh_rep          <= '0;
            sh_div          <= '0;
            irq_en          <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sh_low[c]  <= '0;
                sh_high[c] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    // Commits to channels that do not exist fall through here
                    if (accept) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (cfg_ch == 2'(c)) begin
                                case (cfg_reg)
                                    2'd0: sh_low[c]  <= cfg_data;
                                    2'd1: sh_high[c] <= cfg_data;
                                    2'd2: begin
                                        sh_rep[c] <= cfg_data[0];
                                        sh_div[c] <= cfg_data[1];
                                        irq_en[c] <= cfg_data[2];
                                    end
                                    default: begin
                                        state     <= LOAD;
                                        cfg_ready <= 1'b0;
                                        cur_ch    <= cfg_ch;
                                        ch_counter_low[8*c +: 8]  <= sh_low[c];
                                        ch_counter_high[8*c +: 8] <= sh_high[c];
                                        ch_repeating[c]    <= sh_rep[c];
                                        ch_divider_on[c]   <= sh_div[c];
                                        ch_write_enable[c] <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                end
                LOAD: begin
                    state <= SETTLE;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (cur_ch == 2'(c)) begin
                            ch_write_enable[c] <= 1'b0;
                        end
                    end
                end
                SETTLE: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        ack_clr = '0;
        en_clr  = '0;
        ovr_clr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ack_clr[c] = irq & irq_ack & (irq_id == ID_W'(c));
            if (ctrl_wr && (cfg_ch == 2'(c))) begin
                en_clr[c]  = ~cfg_data[2] & ~(irq && (irq_id == ID_W'(c)));
                ovr_clr[c] = cfg_data[3];
            end
        end
        pend_set = ch_interrupting & irq_en;
        ovr_set  = pend_set & pending & ~ack_clr;
    end

`ifdef PIT_RR_ARB_EN
    logic [ID_W-1:0] last;
    int              best;
    int              dist;

    // Distance from the slot after the last grant decides the winner
    always_comb begin
        grant_id = '0;
        best     = NUM_CH;
        dist     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            dist = (i + 2 * NUM_CH - int'(last) - 1) % NUM_CH;
            if (pending[i] && (dist < best)) begin
                best     = dist;
                grant_id = ID_W'(i);
            end
        end
    end
`else
    always_comb begin
        grant_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_id = ID_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            overrun <= '0;
            irq     <= 1'b0;
            irq_id  <= '0;
`ifdef PIT_RR_ARB_EN
            last    <= ID_W'(NUM_CH - 1);
`endif
        end else begin
            pending <= (pending & ~(ack_clr | en_clr)) | pend_set;
            overrun <= (overrun & ~ovr_clr) | ovr_set;
            if (irq) begin
                if (irq_ack) begin
                    irq <= 1'b0;
                end
            end else if (|pending) begin
                irq    <= 1'b1;
                irq_id <= grant_id;
`ifdef PIT_RR_ARB_EN
                last   <= grant_id;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pit_irq_sequencer.sv
// Scoreboard bench for pit_irq_sequencer: config sequencing, arbitration,
// overrun and reset recovery; a second NUM_CH=3 instance covers out-of-range commits.
module tb_pit_irq_sequencer;

    localparam int NUM_CH = 4;
    localparam int ID_W   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset = 1'b1;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [3:0]          cfg_addr = '0;
    logic [7:0]          cfg_data = '0;
    logic [NUM_CH-1:0]   ch_write_enable;
    logic [8*NUM_CH-1:0] ch_counter_high;
    logic [8*NUM_CH-1:0] ch_counter_low;
    logic [NUM_CH-1:0]   ch_repeating;
    logic [NUM_CH-1:0]   ch_divider_on;
    logic [NUM_CH-1:0]   ch_interrupting = '0;
    logic                irq;
    logic [ID_W-1:0]     irq_id;
    logic                irq_ack = 1'b0;
    logic [NUM_CH-1:0]   overrun;

    logic        cfg_valid3 = 1'b0;
    logic        cfg_ready3;
    logic [3:0]  cfg_addr3 = '0;
    logic [7:0]  cfg_data3 = '0;
    logic [2:0]  we3;
    logic [23:0] high3;
    logic [23:0] low3;
    logic [2:0]  rep3;
    logic [2:0]  div3;
    logic [2:0]  int3 = '0;
    logic        irq3;
    logic [1:0]  irq_id3;
    logic        irq_ack3 = 1'b0;
    logic [2:0]  overrun3;

    pit_irq_sequencer #(.NUM_CH(NUM_CH), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .ch_write_enable(ch_write_enable),
        .ch_counter_high(ch_counter_high),
        .ch_counter_low(ch_counter_low),
        .ch_repeating(ch_repeating), .ch_divider_on(ch_divider_on),
        .ch_interrupting(ch_interrupting),
        .irq(irq), .irq_id(irq_id), .irq_ack(irq_ack),
        .overrun(overrun)
    );

    pit_irq_sequencer #(.NUM_CH(3), .ID_W(2)) dut3 (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_addr(cfg_addr3), .cfg_data(cfg_data3),
        .ch_write_enable(we3),
        .ch_counter_high(high3), .ch_counter_low(low3),
        .ch_repeating(rep3), .ch_divider_on(div3),
        .ch_interrupting(int3),
        .irq(irq3), .irq_id(irq_id3), .irq_ack(irq_ack3),
        .overrun(overrun3)
    );

    int checks = 0;
    int errors = 0;
    logic [ID_W-1:0] exp_q[$];
    logic [ID_W-1:0] exp_id;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] rg,
                             input logic [7:0] d);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_addr  = {ch, rg};
        cfg_data  = d;
        while (!cfg_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_write_wait ready=%b required=1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready);
        end
        checks++;
        if (ch_write_enable !== 4'hF) begin
            errors++;
            $display("FAIL reset_strobes got=%h exp=f", ch_write_enable);
        end
        checks++;
        if (irq !== 1'b0 || irq_id !== 2'd0 || overrun !== 4'h0) begin
            errors++;
            $display("FAIL reset_irq got=%b/%0d/%h exp=0/0/0",
                     irq, irq_id, overrun);
        end
        checks++;
        if (ch_counter_low !== '0 || ch_counter_high !== '0 ||
            ch_repeating !== '0 || ch_divider_on !== '0) begin
            errors++;
            $display("FAIL reset_counts got=%h/%h/%h/%h exp=0",
                     ch_counter_low, ch_counter_high,
                     ch_repeating, ch_divider_on);
        end
    endtask

    task automatic test_config();
        cfg_write(2'd1, 2'd0, 8'h05);
        cfg_write(2'd1, 2'd1, 8'h00);
        cfg_write(2'd1, 2'd2, 8'h05);
        cfg_valid = 1'b1;
        cfg_addr  = {2'd1, 2'd3};
        cfg_data  = 8'h00;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL commit_ready got=%b exp=1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        checks++;
        if (ch_counter_low[15:8] !== 8'h05 || ch_repeating[1] !== 1'b1 ||
            ch_divider_on[1] !== 1'b0 || ch_counter_high[15:8] !== 8'h00) begin
            errors++;
            $display("FAIL commit_load got=%h/%b/%b exp=05/1/0",
                     ch_counter_low[15:8], ch_repeating[1], ch_divider_on[1]);
        end
        checks++;
        if (ch_write_enable !== 4'hF || cfg_ready !== 1'b0 ||
            ch_counter_low[7:0] !== 8'h00) begin
            errors++;
            $display("FAIL commit_t1 got=%h/%b exp=f/0",
                     ch_write_enable, cfg_ready);
        end
        step();
        checks++;
        if (ch_write_enable !== 4'b1101 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL commit_t2 got=%b/%b exp=1101/0",
                     ch_write_enable, cfg_ready);
        end
        step();
        checks++;
        if (ch_write_enable !== 4'b1101 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL commit_t3 got=%b/%b exp=1101/1",
                     ch_write_enable, cfg_ready);
        end
    endtask

    task automatic test_irq_basic();
        cfg_write(2'd2, 2'd2, 8'h04);
        exp_q.push_back(2'd2);
        ch_interrupting = 4'b0100;
        step();
        ch_interrupting = '0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL basic_t1 irq=%b exp=0", irq);
        end
        step();
        exp_id = exp_q.pop_front();
        checks++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            errors++;
            $display("FAIL basic_grant got=%b/%0d exp=1/%0d", irq, irq_id, exp_id);
        end
        step();
        step();
        irq_ack = 1'b1;
        checks++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            errors++;
            $display("FAIL basic_hold got=%b/%0d exp=1/%0d", irq, irq_id, exp_id);
        end
        step();
        irq_ack = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack irq=%b exp=0", irq);
        end
        step();
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL basic_cleared irq=%b exp=0", irq);
        end
    endtask

    task automatic test_priority();
        cfg_write(2'd0, 2'd2, 8'h04);
        cfg_write(2'd3, 2'd2, 8'h04);
`ifdef PIT_RR_ARB_EN
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
`else
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
`endif
        ch_interrupting = 4'b1001;
        step();
        ch_interrupting = '0;
        step();
        exp_id = exp_q.pop_front();
        checks++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            errors++;
            $display("FAIL prio_first got=%b/%0d exp=1/%0d", irq, irq_id, exp_id);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL prio_gap irq=%b exp=0", irq);
        end
        step();
        exp_id = exp_q.pop_front();
        checks++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            errors++;
            $display("FAIL prio_second got=%b/%0d exp=1/%0d", irq, irq_id, exp_id);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL prio_done irq=%b exp=0", irq);
        end
    endtask

    task automatic test_overrun();
        exp_q.push_back(2'd1);
        ch_interrupting = 4'b0010;
        step();
        step();
        ch_interrupting = '0;
        exp_id = exp_q.pop_front();
        checks++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            errors++;
            $display("FAIL ovr_grant got=%b/%0d exp=1/%0d", irq, irq_id, exp_id);
        end
        checks++;
        if (overrun !== 4'b0010) begin
            errors++;
            $display("FAIL ovr_set got=%b exp=0010", overrun);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        step();
        checks++;
        if (irq !== 1'b0 || overrun !== 4'b0010) begin
            errors++;
            $display("FAIL ovr_sticky got=%b/%b exp=0/0010", irq, overrun);
        end
        cfg_write(2'd1, 2'd2, 8'h0D);
        checks++;
        if (overrun !== 4'b0000) begin
            errors++;
            $display("FAIL ovr_clear got=%b exp=0000", overrun);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        ch_interrupting = 4'b0010;
        step();
        ch_interrupting = '0;
        step();
        exp_id = exp_q.pop_front();
        checks++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            errors++;
            $display("FAIL b2b_first got=%b/%0d exp=1/%0d", irq, irq_id, exp_id);
        end
        irq_ack = 1'b1;
        ch_interrupting = 4'b0010;
        step();
        irq_ack = 1'b0;
        ch_interrupting = '0;
        checks++;
        if (irq !== 1'b0 || overrun !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_gap got=%b/%b exp=0/0000", irq, overrun);
        end
        step();
        exp_id = exp_q.pop_front();
        checks++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            errors++;
            $display("FAIL b2b_second got=%b/%0d exp=1/%0d", irq, irq_id, exp_id);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
    endtask

    task automatic test_disabled();
        logic seen;
        seen = 1'b0;
        cfg_write(2'd2, 2'd2, 8'h00);
        ch_interrupting = 4'b0100;
        step();
        ch_interrupting = '0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | irq;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL disabled_irq seen=%b exp=0", seen);
        end
        cfg_valid3 = 1'b1;
        cfg_addr3  = {2'd3, 2'd3};
        step();
        cfg_valid3 = 1'b0;
        step();
        checks++;
        if (we3 !== 3'b111 || cfg_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL oob_commit got=%b/%b exp=111/1", we3, cfg_ready3);
        end
        cfg_valid3 = 1'b1;
        cfg_addr3  = {2'd2, 2'd3};
        step();
        cfg_valid3 = 1'b0;
        step();
        checks++;
        if (we3 !== 3'b011 || cfg_ready3 !== 1'b0) begin
            errors++;
            $display("FAIL ch3_commit got=%b/%b exp=011/0", we3, cfg_ready3);
        end
        step();
    endtask

    task automatic test_reset_mid();
        cfg_write(2'd0, 2'd2, 8'h04);
        ch_interrupting = 4'b0001;
        step();
        ch_interrupting = '0;
        step();
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_grant got=%b/%0d exp=1/0", irq, irq_id);
        end
        cfg_valid = 1'b1;
        cfg_addr  = {2'd0, 2'd3};
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0 || ch_write_enable !== 4'b1101) begin
            errors++;
            $display("FAIL mid_load got=%b/%b exp=0/1101",
                     cfg_ready, ch_write_enable);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (ch_write_enable !== 4'hF || irq !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got=%h/%b/%b exp=f/0/1",
                     ch_write_enable, irq, cfg_ready);
        end
        checks++;
        if (ch_counter_low !== '0 || ch_repeating !== '0 || overrun !== '0) begin
            errors++;
            $display("FAIL mid_reset_regs got=%h/%b/%b exp=0",
                     ch_counter_low, ch_repeating, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_irq_basic();
        test_priority();
        test_overrun();
        test_back_to_back();
        test_disabled();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pit_irq_sequencer.md
Name: pit_irq_sequencer

Overview:
- Front-end controller for a bank of NUM_CH programmable interval timer channels.
- Accepts byte-wide configuration writes, keeps per-channel shadow registers, and sequences each channel's load strobe so a channel starts counting only after it has been fully configured.
- Collects the one-cycle interrupt pulses from all channels into pending bits and arbitrates them onto a single irq/irq_id/irq_ack handshake.
- Sits between the JTAG-driven register bus and the timer channel instances.

Parameters:
- NUM_CH, 4: number of timer channels (1..4); cfg_addr channel field is 2 bits.
- ID_W, 2: width of irq_id; must be at least clog2(NUM_CH).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when cfg_valid & cfg_ready.
- cfg_addr  in  4  [3:2] channel, [1:0] reg: 0=count low, 1=count high, 2=control, 3=commit.
- cfg_data  in  8  write data; control bits: [0] repeating, [1] divider_on, [2] irq_en, [3] clear overrun.
- ch_write_enable  out  NUM_CH  per-channel load strobe to the timer.
- ch_counter_high  out  8*NUM_CH  count high byte, channel c at [8c+7:8c].
- ch_counter_low  out  8*NUM_CH  count low byte, same packing.
- ch_repeating  out  NUM_CH  per-channel repeat mode.
- ch_divider_on  out  NUM_CH  per-channel divide-by-11 prescale.
- ch_interrupting  in  NUM_CH  one-cycle interrupt pulses from the channels.
- irq  out  1  interrupt request to the consumer.
- irq_id  out  ID_W  channel being serviced; valid while irq=1.
- irq_ack  in  1  consumer acknowledge.
- overrun  out  NUM_CH  sticky: a pulse arrived while that channel was already pending.

Behaviour:
- Reset values: ch_write_enable all 1; all count/mode outputs 0; shadows 0; irq_en 0; pending 0; overrun 0; irq 0; irq_id 0; FSM IDLE; cfg_ready 1.
- While ch_write_enable[c]=1 the channel is held loading and does not count. It starts counting the cycle after the strobe drops.
- Config FSM has three states: IDLE, LOAD, SETTLE. cfg_ready=1 only in IDLE.
- Writes to regs 0/1/2 accepted in IDLE: update the shadow on the next edge; FSM stays IDLE; cfg_ready stays 1.
- Control write: irq_en takes effect on the next edge. If data[3]=1, overrun[c] clears. Writing irq_en=0 also clears pending[c], unless c is currently granted.
- Commit accepted in IDLE at cycle T:
  - T+1, state LOAD: shadow copied to channel c outputs; ch_write_enable[c]=1.
  - T+2, state SETTLE: ch_write_enable[c]=0.
  - T+3: IDLE, cfg_ready=1.
  - Outputs of other channels are untouched.
- Re-commit of a running channel re-pulses the strobe for exactly one cycle (LOAD). The channel's running count is not reset by this block.
- Any write while cfg_ready=0 is not accepted; the requester must hold cfg_valid.
- Commit to a channel index ≥ NUM_CH: accepted, FSM stays IDLE, no effect.
- Pending: ch_interrupting[c]=1 at cycle T with irq_en[c]=1 sets pending[c] at T+1. If pending[c] was already 1 (and not being cleared by an ack that cycle), overrun[c] sets instead. Pulses with irq_en[c]=0 are dropped.
- Arbitration (irq=0, any pending): grant at the next edge. irq=1; irq_id = lowest pending index. Minimum pulse-to-irq latency is 2 cycles.
- irq_id is held stable while irq=1. New pending bits do not preempt the grant.
- Ack: irq_ack=1 while irq=1 clears pending[irq_id] and drops irq on the next edge. The next grant can be issued one cycle after that (irq low for at least 1 cycle). irq_ack while irq=0 is ignored.
- Ack and a new pulse on the same channel in the same cycle: pending stays 1, overrun unchanged.
- reset mid-LOAD or mid-service returns everything to reset values, including re-asserting all strobes.

Optional Feature:
- Macro: PIT_RR_ARB_EN.
- Defined: round-robin arbitration. Search starts at (last granted id + 1) mod NUM_CH; last-granted register resets to NUM_CH-1.
- Undefined: fixed priority, lowest index wins. No last-grant register is built.

Test Plan:
- After reset, cfg_ready=1, all ch_write_enable=1. Write ch1 low=0x05, high=0x00, control=0x05, then commit → ch_counter_low[15:8]=0x05 and ch_repeating[1]=1 at commit+1; ch_write_enable[1]=0 at commit+2; cfg_ready=1 at commit+3.
- ch_interrupting[2] pulse at T with irq_en[2]=1 → irq=1, irq_id=2 at T+2. Ack at T+4 → irq=0 at T+5, pending[2]=0.
- Pulses on ch0 and ch3 in the same cycle:
  - Fixed priority → grant 0, ack, then grant 3 after one idle cycle.
  - With PIT_RR_ARB_EN and last grant=0 → grant 3 first.
- Two pulses on ch1 before any ack → overrun[1]=1 stays set. Control write with data[3]=1 → overrun[1]=0.
- Pulse on ch2 with irq_en[2]=0 → no irq, no pending. Commit to channel 3 with NUM_CH=3 → no strobe changes.
- Assert reset during LOAD → next cycle all strobes 1, irq=0, cfg_ready=1.
